// File: rtl/uart_rx_pkg.sv
// Shared types and sizing helpers for the UART operand receiver.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int SYNC_STAGES    = 2;

    function automatic int bytes_total(input int operand_width, input int num_operands);
        return num_operands * (operand_width / UART_DATA_BITS);
    endfunction

    // Counter width able to hold max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: line synchroniser, start-glitch rejection, mid-bit
// sampling and stop-bit framing check. Strobes qualify the stop-sample cycle.
module uart_rx_byte
    import uart_rx_pkg::*;
#(
    parameter int BAUDRATE_VALUE = 325
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_abort,
    input  logic                      i_rx_serial,
    output logic [UART_DATA_BITS-1:0] o_byte,
    output logic                      o_byte_vld,
    output logic                      o_frame_err,
    output logic                      o_start,
    output logic                      o_busy
);

    localparam int HALF   = BAUDRATE_VALUE / 2;
    localparam int BAUD_W = cnt_width(BAUDRATE_VALUE - 1);
    localparam int BIT_W  = cnt_width(UART_DATA_BITS - 1);

    localparam logic [BAUD_W-1:0] HALF_M1  = BAUD_W'(HALF - 1);
    localparam logic [BAUD_W-1:0] BAUD_M1  = BAUD_W'(BAUDRATE_VALUE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

    logic [SYNC_STAGES-1:0]    sync_q;
    logic                      line;
    rx_state_t                 state;
    logic [BAUD_W-1:0]         baud_cnt;
    logic [BIT_W-1:0]          bit_cnt;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      bit_tick;
    logic                      stop_tick;

    assign line      = sync_q[SYNC_STAGES-1];
    assign bit_tick  = (baud_cnt == BAUD_M1);
    assign stop_tick = !i_abort && (state == STOP) && bit_tick;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q   <= '1;
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx_serial};
            if (i_abort) begin
                state    <= IDLE;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!line) begin
                            state    <= START;
                            baud_cnt <= '0;
                            bit_cnt  <= '0;
                        end
                    end
                    START: begin
                        // Mid start bit: a line back high means it was a glitch.
                        if (baud_cnt == HALF_M1) begin
                            baud_cnt <= '0;
                            state    <= line ? IDLE : DATA;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (bit_tick) begin
                            baud_cnt <= '0;
                            shift_q  <= {line, shift_q[UART_DATA_BITS-1:1]};
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                state   <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (bit_tick) begin
                            baud_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign o_byte      = shift_q;
    assign o_byte_vld  = stop_tick && line;
    assign o_frame_err = stop_tick && !line;
    assign o_start     = !i_abort && (state == IDLE) && !line;
    assign o_busy      = (state != IDLE);

endmodule

// File: rtl/uart_rx_operand_packer.sv
// Packs received UART bytes little-endian into NUM_OPERANDS operands and
// reports complete packets, framing errors and inter-byte timeouts.
module uart_rx_operand_packer
    import uart_rx_pkg::*;
#(
    parameter int OPERAND_WIDTH  = 32,
    parameter int NUM_OPERANDS   = 2,
    parameter int BAUDRATE_VALUE = 325,
    parameter int TIMEOUT_BITS   = 20
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_rx_en,
    input  logic                                  i_rx_serial,
    output logic [NUM_OPERANDS*OPERAND_WIDTH-1:0] o_data,
    output logic                                  o_valid,
    output logic                                  o_frame_err,
    output logic                                  o_timeout,
    output logic                                  o_busy
);

    localparam int PKT_W       = NUM_OPERANDS * OPERAND_WIDTH;
    localparam int BYTES_TOTAL = bytes_total(OPERAND_WIDTH, NUM_OPERANDS);
    localparam int BCNT_W      = cnt_width(BYTES_TOTAL - 1);
    localparam int TO_MAX      = TIMEOUT_BITS * BAUDRATE_VALUE;
    localparam int TO_W        = cnt_width(TO_MAX - 1);

    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_TOTAL - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_MAX - 1);

    if ((OPERAND_WIDTH < 8) || (OPERAND_WIDTH % 8 != 0) || (NUM_OPERANDS < 1) ||
        (BAUDRATE_VALUE < 4) || (TIMEOUT_BITS < 1)) begin : g_bad_params
        $error("uart_rx_operand_packer: unsupported parameter combination");
    end

    logic [1:0] rst_sync_q;
    logic       rst_int;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst_int = rst_sync_q[1];

    logic                      abort;
    logic [UART_DATA_BITS-1:0] byte_p0;
    logic                      vld_p0;
    logic                      ferr_p0;
    logic                      start_p0;
    logic                      rx_busy;

    assign abort = !i_rx_en;

    uart_rx_byte #(
        .BAUDRATE_VALUE (BAUDRATE_VALUE)
    ) u_rx_byte (
        .i_clk       (i_clk),
        .i_rst       (rst_int),
        .i_abort     (abort),
        .i_rx_serial (i_rx_serial),
        .o_byte      (byte_p0),
        .o_byte_vld  (vld_p0),
        .o_frame_err (ferr_p0),
        .o_start     (start_p0),
        .o_busy      (rx_busy)
    );

    logic [BCNT_W-1:0] byte_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [PKT_W-1:0]  pkt_q;
    logic [PKT_W-1:0]  pkt_next;

    // Buffer with the incoming byte merged, so the last byte reaches o_data directly.
    always_comb begin
        pkt_next = pkt_q;
        pkt_next[UART_DATA_BITS*int'(byte_cnt) +: UART_DATA_BITS] = byte_p0;
    end

    // ---- stage p1: packing, timeout and registered event pulses ----
    always_ff @(posedge i_clk or posedge rst_int) begin
        if (rst_int) begin
            byte_cnt    <= '0;
            to_cnt      <= '0;
            pkt_q       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_timeout   <= 1'b0;
            if (abort) begin
                byte_cnt <= '0;
                to_cnt   <= '0;
            end else if (vld_p0) begin
                to_cnt <= '0;
                pkt_q  <= pkt_next;
                if (byte_cnt == LAST_BYTE) begin
                    byte_cnt <= '0;
                    o_data   <= pkt_next;
                    o_valid  <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end else if (ferr_p0) begin
                byte_cnt    <= '0;
                to_cnt      <= '0;
                o_frame_err <= 1'b1;
            end else if (start_p0 || rx_busy || (byte_cnt == '0)) begin
                // A start bit in the expiry cycle wins over the timeout.
                to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
                to_cnt    <= '0;
                byte_cnt  <= '0;
                o_timeout <= 1'b1;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign o_busy = rx_busy || (byte_cnt != '0);

endmodule

// File: tb/tb_uart_rx_operand_packer.sv
// Bench for uart_rx_operand_packer: table vectors, corner sequences and a
// randomized byte stream checked against a queue-based packet model.
module tb_uart_rx_operand_packer;

    localparam int B      = 16;
    localparam int T      = 20;
    localparam int HALF   = B / 2;
    localparam int LAT_LO = 9 * B + HALF;
    localparam int LAT_HI = 10 * B;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        ser;
    logic        ser2;
    logic [63:0] data;
    logic        valid, ferr, tout, busy;
    logic [47:0] data2;
    logic        valid2, ferr2, tout2, busy2;

    always #5 clk = ~clk;

    uart_rx_operand_packer #(
        .OPERAND_WIDTH (32), .NUM_OPERANDS (2), .BAUDRATE_VALUE (B), .TIMEOUT_BITS (T)
    ) dut (
        .i_clk (clk), .i_rst (rst), .i_rx_en (en), .i_rx_serial (ser),
        .o_data (data), .o_valid (valid), .o_frame_err (ferr), .o_timeout (tout), .o_busy (busy)
    );

    uart_rx_operand_packer #(
        .OPERAND_WIDTH (16), .NUM_OPERANDS (3), .BAUDRATE_VALUE (B), .TIMEOUT_BITS (T)
    ) dut3 (
        .i_clk (clk), .i_rst (rst), .i_rx_en (en), .i_rx_serial (ser2),
        .o_data (data2), .o_valid (valid2), .o_frame_err (ferr2), .o_timeout (tout2), .o_busy (busy2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_valid = 0, n_ferr = 0, n_tout = 0, n_valid2 = 0, n_err2 = 0;
    int v_cyc = 0, t_cyc = 0, v2_cyc = 0, fstart = 0;
    int e_valid = 0, e_ferr = 0, e_tout = 0;
    logic [63:0] e_data = 64'h0;
    logic [7:0]  q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid)  begin n_valid++;  v_cyc = cyc; end
        if (ferr)   n_ferr++;
        if (tout)   begin n_tout++;   t_cyc = cyc; end
        if (valid2) begin n_valid2++; v2_cyc = cyc; end
        if (ferr2 || tout2) n_err2++;
        if (valid || ferr || tout) begin
            checks++;
            if (int'(valid) + int'(ferr) + int'(tout) > 1) begin
                errors++;
                $display("FAIL pulse_exclusive: valid=%0b frame_err=%0b timeout=%0b at cycle %0d", valid, ferr, tout, cyc);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) ser2 = v;
        else     ser  = v;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good, input bit sel);
        fstart = cyc;
        drive(sel, 1'b0);
        wait_n(B);
        for (int i = 0; i < 8; i++) begin
            drive(sel, b[i]);
            wait_n(B);
        end
        drive(sel, good);
        wait_n(B);
        drive(sel, 1'b1);
    endtask

    function automatic logic [63:0] pack_queue();
        logic [63:0] r = 64'h0;
        for (int i = 0; i < q.size(); i++) r[8*i +: 8] = q[i];
        return r;
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            q.delete();
            e_ferr++;
        end else begin
            q.push_back(b);
            if (q.size() == 8) begin
                e_data = pack_queue();
                e_valid++;
                q.delete();
            end
        end
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, " valid_count"}, n_valid, e_valid);
        chk({tag, " frame_err_count"}, n_ferr, e_ferr);
        chk({tag, " timeout_count"}, n_tout, e_tout);
        chk({tag, " data"}, data, e_data);
    endtask

    typedef struct {
        logic [7:0]  b [8];
        int          nb;
        int          bad;
        int          dv;
        int          df;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0].b = '{8'hA6, 8'hC0, 8'hB0, 8'hC0, 8'hA6, 8'hC0, 8'hB0, 8'hC0};
        vecs[0].nb = 8; vecs[0].bad = -1; vecs[0].dv = 1; vecs[0].df = 0; vecs[0].exp_data = 64'hC0B0C0A6_C0B0C0A6;
        vecs[1].b = '{8'hA6, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1].nb = 2; vecs[1].bad = 1; vecs[1].dv = 0; vecs[1].df = 1; vecs[1].exp_data = 64'hC0B0C0A6_C0B0C0A6;
        vecs[2].b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        vecs[2].nb = 8; vecs[2].bad = -1; vecs[2].dv = 1; vecs[2].df = 0; vecs[2].exp_data = 64'h88776655_44332211;
        vecs[3].b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        vecs[3].nb = 8; vecs[3].bad = 7; vecs[3].dv = 0; vecs[3].df = 1; vecs[3].exp_data = 64'h88776655_44332211;
        vecs[4].b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
        vecs[4].nb = 8; vecs[4].bad = -1; vecs[4].dv = 1; vecs[4].df = 0; vecs[4].exp_data = 64'h67452301_EFBEADDE;

        rst = 1'b1; en = 1'b1; ser = 1'b1; ser2 = 1'b1;
        wait_n(3);
        chk("reset data", data, 64'h0);
        chk("reset valid", valid, 1'b0);
        chk("reset frame_err", ferr, 1'b0);
        chk("reset timeout", tout, 1'b0);
        chk("reset busy", busy, 1'b0);
        rst = 1'b0;
        wait_n(5);
        chk("post-reset busy", busy, 1'b0);
        chk("post-reset data2", data2, 64'h0);

        // Table vectors
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < vecs[v].nb; k++) send_byte(vecs[v].b[k], (k != vecs[v].bad), 1'b0);
            wait_n(20);
            e_valid += vecs[v].dv;
            e_ferr  += vecs[v].df;
            e_data   = vecs[v].exp_data;
            chk_counts("table");
            chk("table busy", busy, 1'b0);
            if (vecs[v].dv != 0) chk_range("table valid latency", v_cyc - fstart, LAT_LO, LAT_HI);
        end

        // Three 16-bit operands on the second instance
        for (int k = 0; k < 6; k++) send_byte(8'(k + 1), 1'b1, 1'b1);
        wait_n(20);
        chk("op3 valid count", n_valid2, 1);
        chk("op3 data", data2, 48'h0605_0403_0201);
        chk("op3 error pulses", n_err2, 0);
        chk("op3 busy", busy2, 1'b0);
        chk_range("op3 valid latency", v2_cyc - fstart, LAT_LO, LAT_HI);

        // Short low glitch on the line
        ser = 1'b0;
        wait_n(4);
        ser = 1'b1;
        wait_n(40);
        chk_counts("glitch");
        chk("glitch busy", busy, 1'b0);

        // Partial packet dropped by timeout, then a clean packet
        for (int k = 0; k < 3; k++) send_byte(8'h5A + 8'(k), 1'b1, 1'b0);
        wait_n(300);
        chk("timeout not early", n_tout, e_tout);
        chk("timeout busy held", busy, 1'b1);
        wait_n(40);
        e_tout++;
        chk_counts("timeout");
        chk_range("timeout latency", t_cyc - fstart, LAT_LO + T * B, LAT_HI + T * B + 4);
        chk("timeout busy cleared", busy, 1'b0);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            send_byte(b, 1'b1, 1'b0);
            model_byte(b, 1'b1);
        end
        wait_n(20);
        chk_counts("after timeout");

        // Enable dropped mid byte 5
        for (int k = 0; k < 4; k++) send_byte(8'hC3 ^ 8'(k), 1'b1, 1'b0);
        ser = 1'b0;
        wait_n(5 * B);
        chk("abort busy before", busy, 1'b1);
        en = 1'b0;
        wait_n(1);
        chk("abort busy next cycle", busy, 1'b0);
        ser = 1'b1;
        wait_n(30);
        en = 1'b1;
        wait_n(5);
        chk_counts("abort");
        for (int k = 0; k < 8; k++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            send_byte(b, 1'b1, 1'b0);
            model_byte(b, 1'b1);
        end
        wait_n(20);
        chk_counts("after abort");

        // Asynchronous reset in the middle of a byte
        ser = 1'b0;
        wait_n(4 * B);
        #2 rst = 1'b1;
        #1;
        chk("async reset data", data, 64'h0);
        chk("async reset busy", busy, 1'b0);
        chk("async reset valid", valid, 1'b0);
        ser = 1'b1;
        wait_n(3);
        rst = 1'b0;
        wait_n(5);
        e_data = 64'h0;
        q.delete();
        for (int k = 0; k < 8; k++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            send_byte(b, 1'b1, 1'b0);
            model_byte(b, 1'b1);
        end
        wait_n(20);
        chk_counts("after reset");

        // Randomized stream with occasional bad stop bits and long idle gaps
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            bit         good;
            int         v_before;
            b        = 8'($urandom_range(0, 255));
            good     = ($urandom_range(0, 9) != 0);
            v_before = e_valid;
            send_byte(b, good, 1'b0);
            model_byte(b, good);
            if (!good) begin
                wait_n(20 + $urandom_range(0, 30));
            end else if ($urandom_range(0, 7) == 0) begin
                wait_n(400);
                if (q.size() != 0) begin
                    e_tout++;
                    q.delete();
                end
            end else begin
                wait_n($urandom_range(0, 30));
            end
            chk_counts("random");
            if (e_valid != v_before) chk_range("random valid latency", v_cyc - fstart, LAT_LO, LAT_HI);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
